// File: rtl/async_crossing_reset_pkg.sv
// Shared types for the async-crossing reset sequencer: FSM encoding and
// counter width derivation.
package async_crossing_reset_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_ASSERT  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RELEASE = 3'd4,
    ST_SETTLE  = 3'd5
  } state_e;

  // Wide enough to hold the largest terminal count plus one spare bit.
  function automatic int cnt_width(input int hold_cycles, input int drain_timeout,
                                   input int settle_cycles);
    int max_v;
    max_v = hold_cycles;
    max_v = (drain_timeout > max_v) ? drain_timeout : max_v;
    max_v = (settle_cycles > max_v) ? settle_cycles : max_v;
    return $clog2(max_v) + 1;
  endfunction

endpackage

// File: rtl/crossing_reset_timer.sv
// Shared phase counter: cleared on every state entry, advanced while enabled,
// and compared against the limit of the current phase.
module crossing_reset_timer #(
  parameter int CNT_W = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             at_limit
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    if (clear) begin
      count_d = {CNT_W{1'b0}};
    end else if (enable) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign at_limit = (count_q == limit);

endmodule

// File: rtl/async_crossing_reset_ctrl.sv
// Source-domain sequencer that drains, resets and reopens an async-queue
// crossing, handshaking reset entry and exit with the sink side.
module async_crossing_reset_ctrl
  import async_crossing_reset_pkg::*;
#(
  parameter int HOLD_CYCLES   = 4,
  parameter int DRAIN_TIMEOUT = 256,
  parameter int SETTLE_CYCLES = 3,
  parameter int CNT_W         = cnt_width(HOLD_CYCLES, DRAIN_TIMEOUT, SETTLE_CYCLES)
) (
  input  logic clock,
  input  logic reset,
  input  logic reset_req,
  input  logic queue_empty,
  input  logic sink_reset_ack,
  output logic enq_block,
  output logic source_reset,
  output logic sink_reset_req,
  output logic busy,
  output logic drain_timeout,
  output logic done
);

  state_e           state_q, state_d;
  logic             reset_req_q;
  logic             start;
  logic             enq_block_q, enq_block_d;
  logic             source_reset_q, source_reset_d;
  logic             sink_reset_req_q, sink_reset_req_d;
  logic             busy_q, busy_d;
  logic             drain_timeout_q, drain_timeout_d;
  logic             done_q, done_d;
  logic             ctr_clear, ctr_enable, ctr_at_limit;
  logic [CNT_W-1:0] ctr_limit;

  assign start = reset_req & ~reset_req_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      reset_req_q      <= 1'b0;
      enq_block_q      <= 1'b0;
      source_reset_q   <= 1'b0;
      sink_reset_req_q <= 1'b0;
      busy_q           <= 1'b0;
      drain_timeout_q  <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      reset_req_q      <= reset_req;
      enq_block_q      <= enq_block_d;
      source_reset_q   <= source_reset_d;
      sink_reset_req_q <= sink_reset_req_d;
      busy_q           <= busy_d;
      drain_timeout_q  <= drain_timeout_d;
      done_q           <= done_d;
    end
  end

  // queue_empty wins over the timeout when both land in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_DRAIN; else state_d = ST_IDLE;
      ST_DRAIN:   if (queue_empty || ctr_at_limit) state_d = ST_ASSERT; else state_d = ST_DRAIN;
      ST_ASSERT:  if (sink_reset_ack) state_d = ST_HOLD; else state_d = ST_ASSERT;
      ST_HOLD:    if (ctr_at_limit) state_d = ST_RELEASE; else state_d = ST_HOLD;
      ST_RELEASE: if (!sink_reset_ack) state_d = ST_SETTLE; else state_d = ST_RELEASE;
      ST_SETTLE:  if (ctr_at_limit) state_d = ST_IDLE; else state_d = ST_SETTLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the flops line up with it.
  always_comb begin
    enq_block_d      = (state_d != ST_IDLE);
    busy_d           = (state_d != ST_IDLE);
    source_reset_d   = (state_d == ST_ASSERT) || (state_d == ST_HOLD);
    sink_reset_req_d = (state_d == ST_ASSERT) || (state_d == ST_HOLD);
    done_d           = (state_q == ST_SETTLE) && (state_d == ST_IDLE);
    if ((state_q == ST_IDLE) && (state_d == ST_DRAIN)) begin
      drain_timeout_d = 1'b0;
    end else if ((state_q == ST_DRAIN) && !queue_empty && ctr_at_limit) begin
      drain_timeout_d = 1'b1;
    end else begin
      drain_timeout_d = drain_timeout_q;
    end
  end

  always_comb begin
    ctr_clear  = (state_d != state_q);
    ctr_enable = 1'b0;
    ctr_limit  = {CNT_W{1'b0}};
    case (state_q)
      ST_DRAIN: begin
        ctr_enable = 1'b1;
        ctr_limit  = CNT_W'(DRAIN_TIMEOUT - 1);
      end
      ST_HOLD: begin
        ctr_enable = 1'b1;
        ctr_limit  = CNT_W'(HOLD_CYCLES - 1);
      end
      ST_SETTLE: begin
        ctr_enable = 1'b1;
        ctr_limit  = CNT_W'(SETTLE_CYCLES - 1);
      end
      default: begin
        ctr_enable = 1'b0;
        ctr_limit  = {CNT_W{1'b0}};
      end
    endcase
  end

  crossing_reset_timer #(.CNT_W(CNT_W)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .clear    (ctr_clear),
    .enable   (ctr_enable),
    .limit    (ctr_limit),
    .at_limit (ctr_at_limit)
  );

  assign enq_block      = enq_block_q;
  assign source_reset   = source_reset_q;
  assign sink_reset_req = sink_reset_req_q;
  assign busy           = busy_q;
  assign drain_timeout  = drain_timeout_q;
  assign done           = done_q;

endmodule
